// File: rtl/ibex_cap_mem_beats_pkg.sv
// Shared types and sizing for the capability memory beat sequencer.
// The beat count is derived from the capability width so the two cannot drift apart.
package ibex_cap_mem_beats_pkg;

    localparam int CAP_WIDTH      = 93;
    localparam int CAP_SLOT_BYTES = 16;

    function automatic int cap_beats(input int width);
        return (width + 31) / 32;
    endfunction

    localparam int CAP_NUM_BEATS = cap_beats(CAP_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } cap_beat_state_e;

endpackage

// File: rtl/ibex_cap_mem_beats.sv
// Splits one capability load/store into 32-bit data-bus beats (beat 0 first) and
// reassembles loads; one outstanding beat at a time, bus outputs from registers only.
module ibex_cap_mem_beats
    import ibex_cap_mem_beats_pkg::*;
#(
    parameter int CapWidth  = CAP_WIDTH,
    parameter int NumBeats  = CAP_NUM_BEATS,
    parameter int SlotBytes = CAP_SLOT_BYTES
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cap_req_i,
    input  logic                cap_we_i,
    input  logic [31:0]         cap_addr_i,
    input  logic [CapWidth-1:0] cap_wdata_i,
    output logic                busy_o,
    output logic                cap_valid_o,
    output logic                cap_err_o,
    output logic [CapWidth-1:0] cap_rdata_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic                data_err_i,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_addr_o,
    output logic [31:0]         data_wdata_o,
    input  logic [31:0]         data_rdata_i
);

    localparam int BeatW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int PadW  = 32 * NumBeats;
    localparam int OffW  = (SlotBytes > 1) ? $clog2(SlotBytes) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

    cap_beat_state_e  state_reg, state_next;
    logic [BeatW-1:0] beat_reg, beat_next;
    logic [31:0]      addr_reg, addr_next;
    logic             we_reg, we_next;
    logic             err_reg, err_next;
    logic [PadW-1:0]  cap_reg, cap_next;

    logic [31:0]      cap_word [NumBeats];
    logic [31:0]      wdata_sel;
    logic             misaligned;

    assign misaligned = |cap_addr_i[OffW-1:0];

    for (genvar gi = 0; gi < NumBeats; gi++) begin : g_word
        assign cap_word[gi] = cap_reg[gi*32 +: 32];
    end

    always_comb begin
        wdata_sel = '0;
        for (int k = 0; k < NumBeats; k++) begin
            if (beat_reg == BeatW'(k)) begin
                wdata_sel = cap_word[k];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        err_next   = err_reg;
        cap_next   = cap_reg;

        case (state_reg)
            IDLE: begin
                if (cap_req_i) begin
                    addr_next  = cap_addr_i;
                    we_next    = cap_we_i;
                    beat_next  = '0;
                    // Loads start from zero so a failed load can never leak stale bits.
                    cap_next   = cap_we_i ? PadW'(cap_wdata_i) : '0;
                    err_next   = misaligned;
                    state_next = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    if (!we_reg) begin
                        for (int k = 0; k < NumBeats; k++) begin
                            if (beat_reg == BeatW'(k)) begin
                                cap_next[k*32 +: 32] = data_rdata_i;
                            end
                        end
                    end
                    if (data_err_i) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else if (beat_reg == LastBeat) begin
                        state_next = DONE;
                    end else begin
                        beat_next  = beat_reg + 1'b1;
                        state_next = REQ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            cap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            err_reg   <= err_next;
            cap_reg   <= cap_next;
        end
    end

    assign busy_o       = (state_reg != IDLE);
    assign cap_valid_o  = (state_reg == DONE);
    assign cap_err_o    = cap_valid_o & err_reg;
    // An errored transfer returns all zeros rather than a partial capability.
    assign cap_rdata_o  = (cap_valid_o && !err_reg && !we_reg) ? cap_reg[CapWidth-1:0] : '0;

    assign data_req_o   = (state_reg == REQ);
    assign data_we_o    = data_req_o & we_reg;
    assign data_be_o    = 4'b1111;
    assign data_addr_o  = data_req_o ? (addr_reg + {{(30-BeatW){1'b0}}, beat_reg, 2'b00}) : '0;
    assign data_wdata_o = data_we_o ? wdata_sel : '0;

endmodule
